// File: rtl/sdram_ctrl_fsm.sv
// sdram_ctrl_fsm: SDRAM timing state machine (power-up init, auto-refresh,
// read/write page bursts). Publishes state codes and a per-state cycle counter
// to the downstream command encoder and returns per-beat acks upstream.
// Build macro: SDRAM_SIM_FAST_INIT_EN -- when defined, the power-up wait is
// 20 cycles and only 2 init auto-refreshes are issued (simulation speed-up).
module sdram_ctrl_fsm #(
    parameter int unsigned POWERUP_CLK = 20000,
    parameter int unsigned TRP_CLK     = 4,
    parameter int unsigned TRC_CLK     = 6,
    parameter int unsigned TRSC_CLK    = 6,
    parameter int unsigned TRCD_CLK    = 2,
    parameter int unsigned TCL_CLK     = 3,
    parameter int unsigned TWR_CLK     = 2,
    parameter int unsigned INIT_AR_NUM = 8,
    parameter int unsigned REF_PERIOD  = 781
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdram_wr_req,
    input  logic       sdram_rd_req,
    input  logic [9:0] sdram_wr_burst,
    input  logic [9:0] sdram_rd_burst,
    output logic [4:0] init_state,
    output logic [3:0] work_state,
    output logic [9:0] cnt_clk,
    output logic       sdram_rd_wr,
    output logic       sdram_wr_ack,
    output logic       sdram_rd_ack,
    output logic       sdram_init_done
);

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned CNT_MAX   = 1023;
    localparam int unsigned BURST_W   = 10;
    localparam int unsigned BURST_MAX = 512;

`ifdef SDRAM_SIM_FAST_INIT_EN
    localparam int unsigned PWR_CYC = 20;
    localparam int unsigned AR_NUM  = 2;
`else
    localparam int unsigned PWR_CYC = POWERUP_CLK;
    localparam int unsigned AR_NUM  = INIT_AR_NUM;
`endif

    localparam int unsigned PWR_W = $clog2(PWR_CYC + 1);
    localparam int unsigned AR_W  = $clog2(AR_NUM + 1);
    localparam int unsigned REF_W = $clog2(REF_PERIOD + 1);

    typedef enum logic [4:0] {
        I_NOP  = 5'd0,
        I_PRE  = 5'd1,
        I_TRP  = 5'd2,
        I_AR   = 5'd3,
        I_TRF  = 5'd4,
        I_MRS  = 5'd5,
        I_TRSC = 5'd6,
        I_DONE = 5'd7
    } init_state_e;

    typedef enum logic [3:0] {
        W_IDLE   = 4'd0,
        W_ACTIVE = 4'd1,
        W_TRCD   = 4'd2,
        W_READ   = 4'd3,
        W_CL     = 4'd4,
        W_RD     = 4'd5,
        W_WRITE  = 4'd6,
        W_WD     = 4'd7,
        W_TWR    = 4'd8,
        W_PRE    = 4'd9,
        W_TRP    = 4'd10,
        W_AR     = 4'd11,
        W_TRFC   = 4'd12
    } work_state_e;

    init_state_e        init_q, init_d;
    work_state_e        work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_wr_q, rd_wr_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [PWR_W-1:0]   pwr_q, pwr_d;
    logic [AR_W-1:0]    ar_q, ar_d;
    logic [REF_W-1:0]   ref_q, ref_d;
    logic               ref_pend_q, ref_pend_d;
    logic               ref_expire_c;

    // Zero-length bursts become single beats; anything above a full page is clamped.
    function automatic logic [BURST_W-1:0] norm_burst(input logic [BURST_W-1:0] b);
        if (b == '0) begin
            return BURST_W'(1);
        end else if (b > BURST_W'(BURST_MAX)) begin
            return BURST_W'(BURST_MAX);
        end else begin
            return b;
        end
    endfunction

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_q     <= I_NOP;
            work_q     <= W_IDLE;
            cnt_q      <= '0;
            rd_wr_q    <= 1'b1;
            burst_q    <= BURST_W'(1);
            pwr_q      <= '0;
            ar_q       <= '0;
            ref_q      <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            init_q     <= init_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            rd_wr_q    <= rd_wr_d;
            burst_q    <= burst_d;
            pwr_q      <= pwr_d;
            ar_q       <= ar_d;
            ref_q      <= ref_d;
            ref_pend_q <= ref_pend_d;
        end
    end

    // Next-state logic for init sequence, refresh timer, work FSM and cycle counter.
    always_comb begin
        init_d       = init_q;
        work_d       = work_q;
        cnt_d        = cnt_q;
        rd_wr_d      = rd_wr_q;
        burst_d      = burst_q;
        pwr_d        = pwr_q;
        ar_d         = ar_q;
        ref_d        = ref_q;
        ref_pend_d   = ref_pend_q;
        ref_expire_c = 1'b0;

        case (init_q)
            I_NOP: begin
                if (pwr_q == PWR_W'(PWR_CYC - 1)) begin
                    init_d = I_PRE;
                end else begin
                    pwr_d = pwr_q + PWR_W'(1);
                end
            end
            I_PRE: init_d = I_TRP;
            I_TRP: begin
                if (cnt_q == CNT_W'(TRP_CLK - 1)) begin
                    init_d = I_AR;
                end
            end
            I_AR: begin
                ar_d   = ar_q + AR_W'(1);
                init_d = I_TRF;
            end
            I_TRF: begin
                if (cnt_q == CNT_W'(TRC_CLK - 1)) begin
                    init_d = (ar_q == AR_W'(AR_NUM)) ? I_MRS : I_AR;
                end
            end
            I_MRS: init_d = I_TRSC;
            I_TRSC: begin
                if (cnt_q == CNT_W'(TRSC_CLK - 1)) begin
                    init_d = I_DONE;
                end
            end
            I_DONE: init_d = I_DONE;
            default: init_d = I_NOP;
        endcase

        // Refresh interval timer only runs once the device is initialised.
        if (init_q == I_DONE) begin
            if (ref_q == REF_W'(REF_PERIOD - 1)) begin
                ref_d        = '0;
                ref_expire_c = 1'b1;
            end else begin
                ref_d = ref_q + REF_W'(1);
            end
        end

        case (work_q)
            W_IDLE: begin
                if (init_q == I_DONE) begin
                    if (ref_pend_q) begin
                        work_d = W_AR;
                    end else if (sdram_wr_req) begin
                        work_d  = W_ACTIVE;
                        rd_wr_d = 1'b0;
                        burst_d = norm_burst(sdram_wr_burst);
                    end else if (sdram_rd_req) begin
                        work_d  = W_ACTIVE;
                        rd_wr_d = 1'b1;
                        burst_d = norm_burst(sdram_rd_burst);
                    end
                end
            end
            W_ACTIVE: work_d = W_TRCD;
            W_TRCD: begin
                if (cnt_q == CNT_W'(TRCD_CLK - 1)) begin
                    work_d = rd_wr_q ? W_READ : W_WRITE;
                end
            end
            W_READ: work_d = W_CL;
            W_CL: begin
                if (cnt_q == CNT_W'(TCL_CLK - 1)) begin
                    work_d = W_RD;
                end
            end
            W_RD: begin
                if (cnt_q == burst_q - BURST_W'(1)) begin
                    work_d = W_PRE;
                end
            end
            W_WRITE: begin
                work_d = (burst_q == BURST_W'(1)) ? W_TWR : W_WD;
            end
            W_WD: begin
                if (cnt_q == burst_q - BURST_W'(2)) begin
                    work_d = W_TWR;
                end
            end
            W_TWR: begin
                if (cnt_q == CNT_W'(TWR_CLK - 1)) begin
                    work_d = W_PRE;
                end
            end
            W_PRE: work_d = W_TRP;
            W_TRP: begin
                if (cnt_q == CNT_W'(TRP_CLK - 1)) begin
                    work_d = W_IDLE;
                end
            end
            W_AR: work_d = W_TRFC;
            W_TRFC: begin
                if (cnt_q == CNT_W'(TRC_CLK - 1)) begin
                    work_d = W_IDLE;
                end
            end
            default: work_d = W_IDLE;
        endcase

        // A fresh expiry re-arms the request even if it coincides with servicing the old one.
        if (ref_expire_c) begin
            ref_pend_d = 1'b1;
        end else if ((work_q == W_IDLE) && (work_d == W_AR)) begin
            ref_pend_d = 1'b0;
        end

        // Per-state elapsed-cycle counter: zero in the first cycle of every new state.
        if ((init_d != init_q) || (work_d != work_q)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Published state and decoded acks.
    assign init_state      = init_q;
    assign work_state      = work_q;
    assign cnt_clk         = cnt_q;
    assign sdram_rd_wr     = rd_wr_q;
    assign sdram_wr_ack    = (work_q == W_WRITE) || (work_q == W_WD);
    assign sdram_rd_ack    = (work_q == W_RD);
    assign sdram_init_done = (init_q == I_DONE);

endmodule

// File: doc/sdram_ctrl_fsm.md
Name: sdram_ctrl_fsm

Overview:
Timing state machine for the SDRAM controller; sits directly upstream of the SDRAM command encoder (sdram_cmd).
- Sequences power-up initialisation, auto-refresh and read/write page bursts.
- Publishes init_state, work_state, cnt_clk and sdram_rd_wr, which the encoder turns into pin commands one cycle later.
- Returns request acks to the FIFO/arbiter layer.

Parameters:
POWERUP_CLK, 20000, power-up NOP wait in clk cycles (200 us at 100 MHz)
TRP_CLK, 4, precharge period, cycles
TRC_CLK, 6, auto-refresh period, cycles
TRSC_CLK, 6, mode-register set period, cycles
TRCD_CLK, 2, activate-to-read/write delay, cycles
TCL_CLK, 3, CAS latency; must equal the CL programmed by the encoder's MRS
TWR_CLK, 2, write recovery, cycles
INIT_AR_NUM, 8, auto-refresh commands during init
REF_PERIOD, 781, cycles between refresh requests (7.8 us)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
sdram_wr_req  input  1  write burst request (level, held until ack)
sdram_rd_req  input  1  read burst request (level, held until ack)
sdram_wr_burst  input  10  write burst length, words
sdram_rd_burst  input  10  read burst length, words
init_state  output  5  init state code
work_state  output  4  work state code
cnt_clk  output  10  cycles elapsed in current state
sdram_rd_wr  output  1  0 = write transaction, 1 = read
sdram_wr_ack  output  1  high once per write data beat (pop FIFO)
sdram_rd_ack  output  1  high once per valid read data beat at DQ
sdram_init_done  output  1  high once init is complete

Behaviour:
Init state codes:
- I_NOP=0, I_PRE=1, I_TRP=2, I_AR=3, I_TRF=4, I_MRS=5, I_TRSC=6, I_DONE=7.

Work state codes:
- W_IDLE=0, W_ACTIVE=1, W_TRCD=2, W_READ=3, W_CL=4, W_RD=5, W_WRITE=6, W_WD=7, W_TWR=8, W_PRE=9, W_TRP=10, W_AR=11, W_TRFC=12.

Reset values (rst sampled on posedge clk; applies immediately, including mid-burst, with no drain):
- init_state=I_NOP, work_state=W_IDLE, cnt_clk=0.
- sdram_rd_wr=1, all acks=0, sdram_init_done=0.
- Refresh timer=0, refresh pending=0, AR count=0.

cnt_clk:
- Cleared on the cycle after any init_state or work_state change.
- Otherwise increments by 1, saturating at 1023.

Init sequence:
- I_NOP for POWERUP_CLK cycles → I_PRE 1 → I_TRP TRP_CLK → I_AR 1 → I_TRF TRC_CLK.
- I_AR/I_TRF repeat until INIT_AR_NUM refreshes are issued.
- Then I_MRS 1 → I_TRSC TRSC_CLK → I_DONE (terminal).
- sdram_init_done = (init_state==I_DONE).
- work_state stays W_IDLE until I_DONE.

Refresh timer:
- Runs only in I_DONE.
- Sets refresh pending at count REF_PERIOD-1, then wraps to 0.
- Pending clears on entering W_AR.
- A new expiry while pending is already set is absorbed.

W_IDLE arbitration, evaluated each cycle, priority refresh > write > read:
- Refresh: → W_AR 1 → W_TRFC TRC_CLK → W_IDLE.
- Write: sdram_rd_wr←0; burst length latched.
- Read: sdram_rd_wr←1; burst length latched.
- sdram_rd_wr holds through the transaction and is unchanged by refresh.

Burst length normalisation:
- 0 is treated as 1.
- Values >512 are clamped to 512.
- Requests are not sampled mid-transaction.

Write path:
- W_ACTIVE 1 → W_TRCD TRCD_CLK → W_WRITE 1 → W_WD burst-1 cycles (skipped if burst=1) → W_TWR TWR_CLK → W_PRE 1 → W_TRP TRP_CLK → W_IDLE.
- sdram_wr_ack is high exactly in the W_WRITE and W_WD cycles: burst pulses total.

Read path:
- W_ACTIVE 1 → W_TRCD TRCD_CLK → W_READ 1 → W_CL TCL_CLK → W_RD burst cycles → W_PRE 1 → W_TRP TRP_CLK → W_IDLE.
- sdram_rd_ack is high exactly in the W_RD cycles.
- Because the encoder adds one register stage, rd_ack aligns with DQ data valid at the pins.

Acks are combinational decodes of registered state: no extra latency.

Optional Feature:
SDRAM_SIM_FAST_INIT_EN:
- Defined: power-up wait is 20 cycles regardless of POWERUP_CLK, and INIT_AR_NUM is forced to 2 (simulation speed-up).
- Undefined: parameter values apply unchanged.

Test Plan:
- Reset, no requests → init_state walks 0,1,2,(3,4)×8,5,6,7; sdram_init_done rises exactly POWERUP_CLK+1+4+8×7+1+6 cycles after reset release.
- After init, wr_req with burst=4 → W_ACTIVE, W_TRCD×2, W_WRITE, W_WD×3; wr_ack high 4 consecutive cycles; sdram_rd_wr=0; back to W_IDLE after TWR+1+TRP.
- rd_req with burst=8 → rd_ack high 8 cycles, starting 1+2+1+3 cycles after W_ACTIVE entry; sdram_rd_wr=1.
- wr_req, rd_req and refresh pending all in the same W_IDLE cycle → W_AR first, then the write, then the read; no ack in the refresh window.
- Bursts of 0 and 1000 → 1 and 512 ack pulses respectively.
- rst asserted mid-W_RD → next cycle all outputs at reset values; init restarts from I_NOP.
